// File: rtl/tron_sram_pkg.sv
// Shared types and constants for the SRAM arbiter.
// Requester slots: background loader, sprite fetch, game logic.
package tron_sram_pkg;

  localparam int NUM_REQ    = 3;
  localparam int REQ_BG     = 0;
  localparam int REQ_SPRITE = 1;
  localparam int REQ_CPU    = 2;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ACCESS,
    ST_DONE
  } state_t;

  function automatic logic [NUM_REQ-1:0] onehot(
    input logic [1:0] idx
  );
    return NUM_REQ'(1) << idx;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Round-robin winner select: searches upward from rr_ptr+1.
// Purely combinational.
module rr_pick
  import tron_sram_pkg::*;
(
  input  logic [NUM_REQ-1:0] req,
  input  logic [1:0]         rr_ptr,
  output logic               valid,
  output logic [1:0]         winner
);

  logic [1:0] w_idx;

  // Walk from farthest to nearest so the nearest request wins.
  always_comb begin
    valid  = 1'b0;
    winner = 2'd0;
    w_idx  = 2'd0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      w_idx = 2'((int'(rr_ptr) + k) % NUM_REQ);
      if (req[w_idx]) begin
        valid  = 1'b1;
        winner = w_idx;
      end
    end
  end

endmodule

// File: rtl/sram_arbiter.sv
// Three-requester arbiter for an async 16-bit SRAM with
// fixed wait states and round-robin fairness.
module sram_arbiter
  import tron_sram_pkg::*;
#(
  parameter int WAIT_CYCLES = 2
) (
  input  logic                      Clk,
  input  logic                      Reset,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ-1:0]        wr,
  input  logic [NUM_REQ-1:0][19:0]  addr,
  input  logic [NUM_REQ-1:0][15:0]  wdata,
  output logic [NUM_REQ-1:0]        done,
  output logic [15:0]               rdata,
  output logic [NUM_REQ-1:0]        grant,
  output logic                      busy,
  output logic [19:0]               SRAM_ADDR,
  inout  wire  [15:0]               SRAM_DQ,
  output logic                      SRAM_CE_N,
  output logic                      SRAM_OE_N,
  output logic                      SRAM_WE_N,
  output logic                      SRAM_UB_N,
  output logic                      SRAM_LB_N
);

  state_t      r_state;
  state_t      w_next;
  logic [1:0]  r_ptr;
  logic [3:0]  r_cnt;
  logic [1:0]  r_win;
  logic        r_wr;
  logic [19:0] r_addr;
  logic [15:0] r_wdata;
  logic [15:0] r_rdata;
  logic        w_valid;
  logic [1:0]  w_winner;
  logic        w_access;
  logic        w_dq_oe;

  rr_pick u_pick (
    .req    (req),
    .rr_ptr (r_ptr),
    .valid  (w_valid),
    .winner (w_winner)
  );

  always_ff @(posedge Clk) begin
    if (Reset) r_state <= ST_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      ST_IDLE:   if (w_valid) w_next = ST_ACCESS;
      ST_ACCESS: if (r_cnt == 4'd0) w_next = ST_DONE;
      ST_DONE:   w_next = ST_IDLE;
      default:   w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_ptr   <= 2'd2;
      r_cnt   <= 4'd0;
      r_win   <= 2'd0;
      r_wr    <= 1'b0;
      r_addr  <= 20'd0;
      r_wdata <= 16'd0;
      r_rdata <= 16'd0;
    end else begin
      unique case (r_state)
        ST_IDLE: begin
          if (w_valid) begin
            r_win   <= w_winner;
            r_addr  <= addr[w_winner];
            r_wr    <= wr[w_winner];
            r_wdata <= wdata[w_winner];
            r_cnt   <= 4'(WAIT_CYCLES - 1);
          end
        end
        ST_ACCESS: begin
          if (r_cnt != 4'd0) r_cnt <= r_cnt - 4'd1;
          else if (!r_wr)    r_rdata <= SRAM_DQ;
        end
        ST_DONE: r_ptr <= r_win;
        default: ;
      endcase
    end
  end

  assign w_access = (r_state == ST_ACCESS);
  // Write data is held through DONE for the SRAM's data-hold time.
  assign w_dq_oe  = r_wr && (w_access || r_state == ST_DONE);

  assign SRAM_DQ   = w_dq_oe ? r_wdata : 16'hzzzz;
  assign SRAM_ADDR = r_addr;
  assign SRAM_CE_N = !w_access;
  assign SRAM_OE_N = !(w_access && !r_wr);
  assign SRAM_WE_N = !(w_access && r_wr);
  assign SRAM_UB_N = !w_access;
  assign SRAM_LB_N = !w_access;

  assign busy  = (r_state != ST_IDLE);
  assign grant = busy ? onehot(r_win) : '0;
  assign done  = (r_state == ST_DONE) ? onehot(r_win) : '0;
  assign rdata = r_rdata;

endmodule

// File: tb/tb_sram_arbiter.sv
// Scoreboard bench for sram_arbiter with a behavioural
// async SRAM model on the shared data bus.
module tb_sram_arbiter;

  logic             Clk = 1'b0;
  logic             Reset = 1'b1;
  logic [2:0]       req = '0;
  logic [2:0]       wr = '0;
  logic [2:0][19:0] addr = '0;
  logic [2:0][15:0] wdata = '0;
  logic [2:0]       done;
  logic [15:0]      rdata;
  logic [2:0]       grant;
  logic             busy;
  logic [19:0]      SRAM_ADDR;
  wire  [15:0]      SRAM_DQ;
  logic             SRAM_CE_N, SRAM_OE_N, SRAM_WE_N;
  logic             SRAM_UB_N, SRAM_LB_N;

  int pass_cnt = 0;
  int total    = 0;

  typedef struct {
    logic [1:0]  idx;
    logic        wr;
    logic [15:0] data;
  } exp_t;
  exp_t sb[$];

  sram_arbiter #(.WAIT_CYCLES(2)) dut (
    .Clk(Clk), .Reset(Reset), .req(req), .wr(wr),
    .addr(addr), .wdata(wdata), .done(done),
    .rdata(rdata), .grant(grant), .busy(busy),
    .SRAM_ADDR(SRAM_ADDR), .SRAM_DQ(SRAM_DQ),
    .SRAM_CE_N(SRAM_CE_N), .SRAM_OE_N(SRAM_OE_N),
    .SRAM_WE_N(SRAM_WE_N), .SRAM_UB_N(SRAM_UB_N),
    .SRAM_LB_N(SRAM_LB_N)
  );

  always #5 Clk = ~Clk;

  // SRAM model: released bus reads as all ones via pullups.
  logic [15:0] mem [logic [19:0]];
  logic [15:0] r_mq = '0;
  logic        w_mdrv;

  function automatic logic [15:0] mdl(input logic [19:0] a);
    if (mem.exists(a)) return mem[a];
    return a[15:0] ^ 16'h5A5A;
  endfunction

  for (genvar g = 0; g < 16; g++) begin : g_pu
    pullup (SRAM_DQ[g]);
  end

  assign w_mdrv = !SRAM_CE_N && !SRAM_OE_N && SRAM_WE_N;
  assign SRAM_DQ = w_mdrv ? r_mq : 16'hzzzz;

  always @(negedge Clk) r_mq <= mdl(SRAM_ADDR);
  always @(posedge Clk)
    if (!SRAM_CE_N && !SRAM_WE_N) mem[SRAM_ADDR] = SRAM_DQ;

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  task automatic do_reset();
    Reset = 1'b1;
    req   = '0;
    wr    = '0;
    @(negedge Clk);
    @(negedge Clk);
    Reset = 1'b0;
  endtask

  task automatic test_reset();
    logic [4:0] strb;
    Reset = 1'b1;
    req   = 3'b111;
    @(negedge Clk);
    @(negedge Clk);
    strb = {SRAM_CE_N, SRAM_OE_N, SRAM_WE_N, SRAM_UB_N, SRAM_LB_N};
    total++;
    if ({busy, grant, done} !== 7'd0)
      $display("FAIL reset_ctl busy/grant/done=%b want 0",
               {busy, grant, done});
    else pass_cnt++;
    total++;
    if (rdata !== 16'h0000)
      $display("FAIL reset_rdata got %h want 0000", rdata);
    else pass_cnt++;
    total++;
    if (strb !== 5'b11111)
      $display("FAIL reset_strobes got %b want 11111", strb);
    else pass_cnt++;
    total++;
    if (SRAM_ADDR !== 20'h0)
      $display("FAIL reset_addr got %h want 00000", SRAM_ADDR);
    else pass_cnt++;
    total++;
    if (SRAM_DQ !== 16'hFFFF)
      $display("FAIL reset_dq got %h want released", SRAM_DQ);
    else pass_cnt++;
    Reset = 1'b0;
    req   = '0;
  endtask

  task automatic test_single_read();
    exp_t e;
    int   lat = 0;
    int   oe_lo = 0;
    bit   got = 0;
    mem[20'h4B000] = 16'h0F0F;
    addr[0] = 20'h4B000;
    wr      = 3'b000;
    req     = 3'b001;
    sb.push_back('{2'd0, 1'b0, 16'h0F0F});
    for (int c = 1; c <= 10 && !got; c++) begin
      @(negedge Clk);
      if (!SRAM_OE_N) oe_lo++;
      if (done != 3'b000) begin
        got = 1;
        lat = c;
      end
    end
    req = 3'b000;
    e = sb.pop_front();
    total++;
    if (!got || lat != 3)
      $display("FAIL rd_latency got %0d want 3 (seen=%0b)", lat, got);
    else pass_cnt++;
    total++;
    if (done !== (3'b001 << e.idx))
      $display("FAIL rd_done got %b want %b", done, 3'b001 << e.idx);
    else pass_cnt++;
    total++;
    if (rdata !== e.data)
      $display("FAIL rd_data got %h want %h", rdata, e.data);
    else pass_cnt++;
    total++;
    if (oe_lo != 2)
      $display("FAIL rd_oe_cycles got %0d want 2", oe_lo);
    else pass_cnt++;
    @(negedge Clk);
    total++;
    if (done !== 3'b000 || busy !== 1'b0)
      $display("FAIL rd_after done=%b busy=%b want 000/0",
               done, busy);
    else pass_cnt++;
  endtask

  task automatic test_write();
    exp_t e;
    int   lat = 0;
    int   we_lo = 0;
    int   dq_bad = 0;
    bit   got = 0;
    addr[2]  = 20'hFFFFF;
    wdata[2] = 16'hBEEF;
    wr       = 3'b100;
    req      = 3'b100;
    sb.push_back('{2'd2, 1'b1, 16'hBEEF});
    for (int c = 1; c <= 10 && !got; c++) begin
      @(negedge Clk);
      if (!SRAM_WE_N) begin
        we_lo++;
        if (SRAM_DQ !== 16'hBEEF) dq_bad++;
      end
      if (done != 3'b000) begin
        got = 1;
        lat = c;
      end
    end
    req = 3'b000;
    wr  = 3'b000;
    e = sb.pop_front();
    total++;
    if (!got || lat != 3)
      $display("FAIL wr_latency got %0d want 3 (seen=%0b)", lat, got);
    else pass_cnt++;
    total++;
    if (we_lo != 2 || dq_bad != 0)
      $display("FAIL wr_strobe we_lo=%0d dq_bad=%0d want 2/0",
               we_lo, dq_bad);
    else pass_cnt++;
    total++;
    if (SRAM_DQ !== e.data || SRAM_WE_N !== 1'b1)
      $display("FAIL wr_hold dq=%h we_n=%b want %h/1",
               SRAM_DQ, SRAM_WE_N, e.data);
    else pass_cnt++;
    total++;
    if (done !== (3'b001 << e.idx))
      $display("FAIL wr_done got %b want %b", done, 3'b001 << e.idx);
    else pass_cnt++;
    total++;
    if (rdata !== 16'h0F0F)
      $display("FAIL wr_rdata got %h want 0f0f", rdata);
    else pass_cnt++;
    total++;
    if (!mem.exists(20'hFFFFF) || mem[20'hFFFFF] !== e.data)
      $display("FAIL wr_stored got %h want %h",
               mdl(20'hFFFFF), e.data);
    else pass_cnt++;
    @(negedge Clk);
    total++;
    if (SRAM_DQ !== 16'hFFFF)
      $display("FAIL wr_release dq=%h want released", SRAM_DQ);
    else pass_cnt++;
  endtask

  task automatic test_contention();
    exp_t e;
    int   ndone = 0;
    int   phase = 0;
    do_reset();
    addr[0] = 20'h00100;
    addr[1] = 20'h00200;
    addr[2] = 20'h00300;
    wr      = 3'b000;
    for (int i = 0; i < 6; i++)
      sb.push_back('{2'(i % 3), 1'b0, mdl(addr[i % 3])});
    req = 3'b111;
    for (int c = 0; c < 60 && ndone < 6; c++) begin
      @(negedge Clk);
      if (phase == 1) begin
        total++;
        if (busy !== 1'b0 || grant !== 3'b000 || done !== 3'b000)
          $display("FAIL cont_idle busy=%b grant=%b done=%b",
                   busy, grant, done);
        else pass_cnt++;
        phase = 2;
      end else if (phase == 2) begin
        total++;
        if (busy !== 1'b1)
          $display("FAIL cont_restart busy=%b want 1", busy);
        else pass_cnt++;
        phase = 0;
      end
      if (done != 3'b000) begin
        e = sb.pop_front();
        total++;
        if (done !== (3'b001 << e.idx) || rdata !== e.data)
          $display("FAIL cont_order%0d done=%b rdata=%h want %b/%h",
                   ndone, done, rdata, 3'b001 << e.idx, e.data);
        else pass_cnt++;
        ndone++;
        phase = 1;
      end
    end
    req = 3'b000;
    total++;
    if (ndone != 6)
      $display("FAIL cont_count got %0d want 6", ndone);
    else pass_cnt++;
    sb.delete();
  endtask

  task automatic test_fairness();
    exp_t e;
    int   ndone = 0;
    do_reset();
    addr[0] = 20'h00010;
    addr[1] = 20'h00020;
    wr      = 3'b000;
    sb.push_back('{2'd0, 1'b0, mdl(20'h00010)});
    sb.push_back('{2'd1, 1'b0, mdl(20'h00020)});
    req = 3'b001;
    @(negedge Clk);
    total++;
    if (grant !== 3'b001)
      $display("FAIL fair_first grant=%b want 001", grant);
    else pass_cnt++;
    req[1] = 1'b1;
    for (int c = 0; c < 20 && ndone < 2; c++) begin
      @(negedge Clk);
      if (done != 3'b000) begin
        e = sb.pop_front();
        total++;
        if (done !== (3'b001 << e.idx) || rdata !== e.data)
          $display("FAIL fair_order%0d done=%b rdata=%h want %b/%h",
                   ndone, done, rdata, 3'b001 << e.idx, e.data);
        else pass_cnt++;
        if (done[1]) req[1] = 1'b0;
        ndone++;
      end
    end
    req = 3'b000;
    total++;
    if (ndone != 2)
      $display("FAIL fair_count got %0d want 2", ndone);
    else pass_cnt++;
    sb.delete();
  endtask

  task automatic test_reset_mid();
    logic [4:0] strb;
    do_reset();
    addr[0]  = 20'h00777;
    wdata[0] = 16'h1234;
    wr       = 3'b001;
    req      = 3'b001;
    @(negedge Clk);
    @(negedge Clk);
    total++;
    if (SRAM_CE_N !== 1'b0 || SRAM_DQ !== 16'h1234)
      $display("FAIL rmid_access ce_n=%b dq=%h want 0/1234",
               SRAM_CE_N, SRAM_DQ);
    else pass_cnt++;
    Reset = 1'b1;
    req   = 3'b000;
    wr    = 3'b000;
    @(negedge Clk);
    strb = {SRAM_CE_N, SRAM_OE_N, SRAM_WE_N, SRAM_UB_N, SRAM_LB_N};
    total++;
    if (strb !== 5'b11111 || SRAM_DQ !== 16'hFFFF)
      $display("FAIL rmid_bus strobes=%b dq=%h want 11111/released",
               strb, SRAM_DQ);
    else pass_cnt++;
    total++;
    if (done !== 3'b000 || busy !== 1'b0)
      $display("FAIL rmid_ctl done=%b busy=%b want 000/0", done, busy);
    else pass_cnt++;
    Reset = 1'b0;
    @(negedge Clk);
    total++;
    if (done !== 3'b000)
      $display("FAIL rmid_nodone done=%b want 000", done);
    else pass_cnt++;
  endtask

  task automatic test_latched();
    exp_t e;
    int   bad = 0;
    bit   got = 0;
    do_reset();
    addr[0] = 20'h12345;
    wr      = 3'b000;
    req     = 3'b001;
    sb.push_back('{2'd0, 1'b0, mdl(20'h12345)});
    @(negedge Clk);
    if (SRAM_ADDR !== 20'h12345) bad++;
    addr[0] = 20'h00ABC;
    wr[0]   = 1'b1;
    for (int c = 0; c < 10 && !got; c++) begin
      @(negedge Clk);
      if (SRAM_ADDR !== 20'h12345) bad++;
      if (done != 3'b000) got = 1;
    end
    req = 3'b000;
    wr  = 3'b000;
    e = sb.pop_front();
    total++;
    if (!got || bad != 0)
      $display("FAIL latch_addr bad_cycles=%0d seen=%0b want 0/1",
               bad, got);
    else pass_cnt++;
    total++;
    if (rdata !== e.data)
      $display("FAIL latch_rdata got %h want %h", rdata, e.data);
    else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_single_read();
    test_write();
    test_contention();
    test_fairness();
    test_reset_mid();
    test_latched();
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule
